// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker states, default tap masks and the one-step
// Fibonacci update used by both the stream generator and the stream checker.
package lfsr_pkg;

  localparam int unsigned MAX_N = 32;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOST
  } state_t;

  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hD008;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  // Maximal-length tap mask for the common widths; anything else gets the 32-bit mask.
  function automatic logic [MAX_N-1:0] default_taps(input int unsigned n);
    case (n)
      4:       return 32'(TAPS_4);
      8:       return 32'(TAPS_8);
      16:      return 32'(TAPS_16);
      default: return TAPS_32;
    endcase
  endfunction

  // Stage i of an n-bit [1:n] word sits at bit n-i of the right-aligned vector,
  // so stage 1 is the top bit and shifting stages up one index is a right shift.
  function automatic logic [MAX_N-1:0] lfsr_next_state(input logic [MAX_N-1:0] cur,
                                                       input logic [MAX_N-1:0] taps,
                                                       input int unsigned n);
    logic fb;
    fb = 1'b0;
    for (int unsigned p = 0; p < MAX_N; p++) begin
      if (p < n) fb ^= cur[5'(p)] & taps[5'(n - 1 - p)];
    end
    return (cur >> 1) | (32'(fb) << (n - 1));
  endfunction

endpackage

// File: rtl/lfsr_stream_checker_next.sv
// Combinational one-step LFSR predictor for an N-bit [1:N] state word.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter logic [N-1:0] TAPS = N'(default_taps(N))
) (
  input  logic [1:N] cur,
  output logic [1:N] pred_c
);

  assign pred_c = N'(lfsr_next_state(32'(cur), 32'(TAPS), N));

endmodule

// File: rtl/lfsr_stream_checker.sv
// LFSR stream checker: locks on the first non-zero word, predicts each following
// word, counts mismatches, drops lock after a run of misses and measures the period.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter logic [N-1:0] TAPS        = N'(default_taps(N)),
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [1:N]       in_q,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             zero_seen,
  output logic [31:0]      period,
  output logic             period_valid
);

  localparam int unsigned MISS_W = $clog2(LOSS_THRESH + 1);

  state_t            state;
  logic [1:N]        expected_src;
  logic [1:N]        lock_word;
  logic [31:0]       wcnt;
  logic [MISS_W-1:0] miss_run;
  logic [1:N]        pred_c;
  logic              zero_c;
  logic              match_c;

  lfsr_next #(.N(N), .TAPS(TAPS)) u_next (
    .cur   (expected_src),
    .pred_c(pred_c)
  );

  // An all-zero word is the lock-up state and never counts as a match.
  assign zero_c  = (in_q == '0);
  assign match_c = !zero_c && (in_q == pred_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      expected_src <= '0;
      lock_word    <= '0;
      wcnt         <= '0;
      miss_run     <= '0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
      zero_seen    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      expected_src <= '0;
      lock_word    <= '0;
      wcnt         <= '0;
      miss_run     <= '0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
      zero_seen    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !zero_c) begin
            lock_word    <= in_q;
            expected_src <= in_q;
            wcnt         <= 32'd1;
            miss_run     <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b1;
            state        <= TRACK;
          end
        end
        TRACK: begin
          if (in_valid) begin
            // Always follow the observed word so a single bad word costs at most two misses.
            expected_src <= in_q;
            if (match_c) begin
              miss_run <= '0;
              if (wcnt != '1) wcnt <= wcnt + 32'd1;
              if (!period_valid && (in_q == lock_word)) begin
                period       <= wcnt;
                period_valid <= 1'b1;
              end
            end else begin
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
              if (zero_c) zero_seen <= 1'b1;
              miss_run <= miss_run + MISS_W'(1);
              if (miss_run == MISS_W'(LOSS_THRESH - 1)) begin
                locked <= 1'b0;
                state  <= LOST;
              end
            end
          end
        end
        LOST: begin
          locked       <= 1'b0;
          miss_run     <= '0;
          period_valid <= 1'b0;
          wcnt         <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scoreboarded bench for lfsr_stream_checker: a behavioural model queues the expected
// outputs per input cycle and a negedge monitor compares them against the 32-bit DUT.
module tb_lfsr_stream_checker;

  localparam int unsigned N      = 32;
  localparam int unsigned THRESH = 4;
  localparam logic [31:0] TAPS32 = 32'h8020_0003;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [1:N]  in_q;
  logic        locked, err_pulse, zero_seen, period_valid;
  logic [15:0] err_count;
  logic [31:0] period;

  logic        in4_valid;
  logic [1:4]  in4_q;
  logic        locked4, err_pulse4, zero_seen4, period_valid4;
  logic [15:0] err_count4;
  logic [31:0] period4;

  lfsr_stream_checker dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_q(in_q),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .zero_seen(zero_seen), .period(period), .period_valid(period_valid)
  );

  lfsr_stream_checker #(.N(4), .TAPS(4'hC)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in4_valid), .in_q(in4_q),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4),
    .zero_seen(zero_seen4), .period(period4), .period_valid(period_valid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        zero_seen;
    logic [31:0] period;
    logic        period_valid;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: mode 0 = waiting for lock, 1 = tracking, 2 = lock just lost.
  int          mode;
  logic [31:0] m_expect, m_lock, m_wcnt;
  int          m_miss;
  exp_t        m_out;
  logic [31:0] gen;

  // Stage i of the word lives at bit n-i; stage 1 takes the feedback, the rest shift up.
  function automatic logic [31:0] ref_next(input logic [31:0] w, input int n, input logic [31:0] taps);
    logic        fb;
    logic [31:0] r;
    fb = 1'b0;
    for (int i = 1; i <= n; i++) fb ^= w[5'(n - i)] & taps[5'(i - 1)];
    r = w >> 1;
    r[5'(n - 1)] = fb;
    return r;
  endfunction

  task automatic model_reset();
    mode = 0; m_expect = '0; m_lock = '0; m_wcnt = '0; m_miss = 0;
    m_out = '{locked: 1'b0, err_pulse: 1'b0, err_count: 16'd0, zero_seen: 1'b0,
              period: 32'd0, period_valid: 1'b0};
  endtask

  task automatic model_step(input logic v, input logic [31:0] q, input logic clr);
    m_out.err_pulse = 1'b0;
    if (clr) model_reset();
    else if (mode == 0) begin
      if (v && q != 0) begin
        m_lock = q; m_expect = q; m_wcnt = 1; m_miss = 0;
        m_out.period_valid = 1'b0; m_out.locked = 1'b1; mode = 1;
      end
    end else if (mode == 1) begin
      if (v) begin
        if (q != 0 && q == ref_next(m_expect, N, TAPS32)) begin
          m_miss = 0;
          if (!m_out.period_valid && q == m_lock) begin
            m_out.period = m_wcnt; m_out.period_valid = 1'b1;
          end
          if (m_wcnt != 32'hFFFF_FFFF) m_wcnt++;
        end else begin
          m_out.err_pulse = 1'b1;
          if (m_out.err_count != 16'hFFFF) m_out.err_count++;
          if (q == 0) m_out.zero_seen = 1'b1;
          m_miss++;
          if (m_miss == THRESH) begin mode = 2; m_out.locked = 1'b0; end
        end
        m_expect = q;
      end
    end else begin
      m_out.locked = 1'b0; m_out.period_valid = 1'b0; m_miss = 0; m_wcnt = 0; mode = 0;
    end
    sb.push_back(m_out);
  endtask

  // One input cycle: drive, queue the expectation, let the edge and the monitor pass.
  task automatic step(input logic v, input logic [31:0] q, input logic clr);
    in_valid = v; in_q = q; clear = clr;
    model_step(v, q, clr);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send_good();
    if ($urandom_range(0, 4) == 0) step(1'b0, $urandom, 1'b0);
    step(1'b1, gen, 1'b0);
    gen = ref_next(gen, N, TAPS32);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (locked !== e.locked || err_pulse !== e.err_pulse || err_count !== e.err_count ||
          zero_seen !== e.zero_seen || period !== e.period || period_valid !== e.period_valid) begin
        fails++;
        $display("FAIL scoreboard @%0t: got lk=%b ep=%b ec=%0d zs=%b per=%0d pv=%b, expected lk=%b ep=%b ec=%0d zs=%b per=%0d pv=%b",
                 $time, locked, err_pulse, err_count, zero_seen, period, period_valid,
                 e.locked, e.err_pulse, e.err_count, e.zero_seen, e.period, e.period_valid);
      end
    end
  end

  initial begin
    logic [3:0]  g4;
    logic [31:0] q;
    int          r;

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_q = '0; in4_valid = 1'b0; in4_q = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_locked", 32'(locked), 0);
    check("reset_err_count", 32'(err_count), 0);
    check("reset_period", period, 0);
    check("reset_period_valid", 32'(period_valid), 0);

    // 4-bit free-running generator seeded with 1: period 15.
    g4 = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      in4_valid = 1'b1; in4_q = g4;
      @(posedge clk);
      #1;
      if (k == 0)  check("n4_locked_after_first", 32'(locked4), 1);
      if (k == 14) check("n4_no_period_yet", 32'(period_valid4), 0);
      g4 = 4'(ref_next(32'(g4), 4, 32'hC));
    end
    in4_valid = 1'b0;
    check("n4_period", period4, 15);
    check("n4_period_valid", 32'(period_valid4), 1);
    check("n4_err_count", 32'(err_count4), 0);
    check("n4_locked", 32'(locked4), 1);
    @(negedge clk);
    #1;

    // Zero words in IDLE are ignored.
    repeat (3) step(1'b1, 32'd0, 1'b0);
    check("idle_zero_no_lock", 32'(locked), 0);
    check("idle_zero_no_err", 32'(err_count), 0);

    // Clean tracking from seed 12.
    gen = 32'h0000_000C;
    for (int w = 0; w < 1000; w++) send_good();
    check("clean_err_count", 32'(err_count), 0);
    check("clean_locked", 32'(locked), 1);

    // One flipped bit (stage 5) costs two mismatches but keeps lock.
    for (int w = 1; w <= 60; w++) begin
      q = gen;
      if (w == 50) q = q ^ (32'h1 << (N - 5));
      step(1'b1, q, 1'b0);
      gen = ref_next(gen, N, TAPS32);
    end
    check("flip_err_count", 32'(err_count), 2);
    check("flip_locked", 32'(locked), 1);

    // Four garbage words drop lock; good words then relock without a period.
    repeat (THRESH) step(1'b1, $urandom | 32'h1, 1'b0);
    check("loss_unlocked", 32'(locked), 0);
    for (int w = 0; w < 20; w++) send_good();
    check("relock_locked", 32'(locked), 1);
    check("relock_period_invalid", 32'(period_valid), 0);

    // Zero word while tracking.
    step(1'b1, 32'd0, 1'b0);
    check("track_zero_seen", 32'(zero_seen), 1);
    for (int w = 0; w < 5; w++) send_good();

    // Asynchronous reset between edges clears outputs immediately.
    #2 reset = 1'b1;
    #1;
    check("async_locked", 32'(locked), 0);
    check("async_err_count", 32'(err_count), 0);
    check("async_zero_seen", 32'(zero_seen), 0);
    model_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    for (int w = 0; w < 10; w++) send_good();
    check("post_reset_relock", 32'(locked), 1);

    // clear beats in_valid.
    step(1'b1, gen, 1'b1);
    check("clear_locked", 32'(locked), 0);
    check("clear_err_count", 32'(err_count), 0);

    // Randomised mix of good, corrupt, zero, garbage, idle and clear cycles.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) send_good();
      else if (r < 80) step(1'b0, $urandom, 1'b0);
      else if (r < 88) begin
        step(1'b1, gen ^ (32'h1 << $urandom_range(0, 31)), 1'b0);
        gen = ref_next(gen, N, TAPS32);
      end else if (r < 93) step(1'b1, 32'd0, 1'b0);
      else if (r < 98) step(1'b1, $urandom, 1'b0);
      else step(1'b0, 32'd0, 1'b1);
    end

    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
